// File: rtl/clksw_sched.sv
// HS/LS CPU clock switch sequencer: chooses fast or slow clock per CPU cycle,
// handshakes with the switch status, and owns the clock configuration register.
module clksw_sched #(
    parameter logic [7:0]  IO_PAGE_LO  = 8'hFC,
    parameter logic [7:0]  IO_PAGE_HI  = 8'hFE,
    parameter int unsigned LS_HOLD     = 4,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic       hsclk_in,
    input  logic       rst_b,
    input  logic       cpu_cyc_start,
    input  logic [7:0] cpu_addr_hi,
    input  logic       cpu_vda,
    input  logic       clk_is_hs,
    input  logic       cfg_wr,
    input  logic [7:0] cfg_wdata,
    output logic       hsclk_sel,
    output logic [1:0] hsclk_div_sel,
    output logic [1:0] cpuclk_div_sel,
    output logic [7:0] cfg_rdata,
    output logic       busy
);

    localparam int unsigned HW = (LS_HOLD > 0) ? $clog2(LS_HOLD + 1) : 1;
    localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(LS_HOLD);
    localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);

    // Encoding is software-visible through cfg_rdata[6:5].
    typedef enum logic [1:0] {
        LS_RUN = 2'd0,
        HS_REQ = 2'd1,
        HS_RUN = 2'd2,
        LS_REQ = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            hsclk_sel_q, hsclk_sel_d;
    logic            turbo_q, turbo_d;
    logic [1:0]      hdiv_pend_q, hdiv_pend_d;
    logic [1:0]      cdiv_pend_q, cdiv_pend_d;
    logic [1:0]      hdiv_app_q, hdiv_app_d;
    logic [1:0]      cdiv_app_q, cdiv_app_d;
    logic            err_q, err_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [TW-1:0]   tmo_q, tmo_d;

    logic            slow_needed;
    logic            want_hs;
    logic            tmo_hit;
    logic            set_err;
    logic            in_req;
    logic            unused_wdata;

    assign unused_wdata = ^cfg_wdata[6:5];

    always_comb begin
        slow_needed = cpu_vda && (cpu_addr_hi >= IO_PAGE_LO) && (cpu_addr_hi <= IO_PAGE_HI);
        want_hs     = turbo_q && !slow_needed && (hold_q == '0);
        tmo_hit     = (tmo_q == TMO_LAST);
        in_req      = (state_q == HS_REQ) || (state_q == LS_REQ);
    end

    always_comb begin
        state_d     = state_q;
        hsclk_sel_d = hsclk_sel_q;
        set_err     = 1'b0;
        case (state_q)
            LS_RUN: begin
                if (cpu_cyc_start && want_hs) begin
                    state_d     = HS_REQ;
                    hsclk_sel_d = 1'b1;
                end
            end
            HS_REQ: begin
                // An acknowledge arriving on the timeout clock still counts.
                if (clk_is_hs) begin
                    state_d = HS_RUN;
                end else if (tmo_hit) begin
                    state_d     = LS_RUN;
                    hsclk_sel_d = 1'b0;
                    set_err     = 1'b1;
                end else if (!turbo_q) begin
                    state_d     = LS_REQ;
                    hsclk_sel_d = 1'b0;
                end
            end
            HS_RUN: begin
                if ((cpu_cyc_start && slow_needed) || !turbo_q) begin
                    state_d     = LS_REQ;
                    hsclk_sel_d = 1'b0;
                end
            end
            LS_REQ: begin
                if (!clk_is_hs) begin
                    state_d = LS_RUN;
                end else if (tmo_hit) begin
                    state_d = LS_RUN;
                    set_err = 1'b1;
                end
            end
            default: begin
                state_d     = LS_RUN;
                hsclk_sel_d = 1'b0;
            end
        endcase
    end

    // Any state change restarts the acknowledge window; it only advances
    // while parked in a request state.
    always_comb begin
        tmo_d = '0;
        if ((state_d == state_q) && in_req) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_comb begin
        hold_d = hold_q;
        if (cpu_cyc_start) begin
            if (slow_needed) begin
                hold_d = HOLD_LOAD;
            end else if (hold_q != '0) begin
                hold_d = hold_q - 1'b1;
            end
        end
    end

    always_comb begin
        turbo_d     = turbo_q;
        hdiv_pend_d = hdiv_pend_q;
        cdiv_pend_d = cdiv_pend_q;
        if (cfg_wr) begin
            turbo_d     = cfg_wdata[0];
            hdiv_pend_d = cfg_wdata[2:1];
            cdiv_pend_d = cfg_wdata[4:3];
        end

        err_d = err_q;
        if (set_err) begin
            err_d = 1'b1;
        end else if (cfg_wr && cfg_wdata[7]) begin
            err_d = 1'b0;
        end

        // Dividers only move while the switch is confirmed parked on the slow clock.
        hdiv_app_d = hdiv_app_q;
        cdiv_app_d = cdiv_app_q;
        if ((state_q == LS_RUN) && !clk_is_hs) begin
            hdiv_app_d = hdiv_pend_q;
            cdiv_app_d = cdiv_pend_q;
        end
    end

    always_ff @(posedge hsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= LS_RUN;
            hsclk_sel_q <= 1'b0;
            turbo_q     <= 1'b0;
            hdiv_pend_q <= '0;
            cdiv_pend_q <= '0;
            hdiv_app_q  <= '0;
            cdiv_app_q  <= '0;
            err_q       <= 1'b0;
            hold_q      <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            hsclk_sel_q <= hsclk_sel_d;
            turbo_q     <= turbo_d;
            hdiv_pend_q <= hdiv_pend_d;
            cdiv_pend_q <= cdiv_pend_d;
            hdiv_app_q  <= hdiv_app_d;
            cdiv_app_q  <= cdiv_app_d;
            err_q       <= err_d;
            hold_q      <= hold_d;
            tmo_q       <= tmo_d;
        end
    end

    assign hsclk_sel      = hsclk_sel_q;
    assign hsclk_div_sel  = hdiv_app_q;
    assign cpuclk_div_sel = cdiv_app_q;
    assign busy           = in_req;
    assign cfg_rdata      = {err_q, state_q, cdiv_pend_q, hdiv_pend_q, turbo_q};

endmodule

// File: tb/tb_clksw_sched.sv
// Bench for clksw_sched: directed vector table, hand sequences for timeout and
// async reset, then randomized traffic against a request/handshake model.
module tb_clksw_sched;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       cpu_cyc_start;
    logic [7:0] cpu_addr_hi;
    logic       cpu_vda;
    logic       clk_is_hs;
    logic       cfg_wr;
    logic [7:0] cfg_wdata;
    logic       hsclk_sel;
    logic [1:0] hsclk_div_sel;
    logic [1:0] cpuclk_div_sel;
    logic [7:0] cfg_rdata;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    clksw_sched #(
        .IO_PAGE_LO (8'hFC),
        .IO_PAGE_HI (8'hFE),
        .LS_HOLD    (4),
        .ACK_TIMEOUT(64)
    ) dut (
        .hsclk_in      (clk),
        .rst_b         (rst_b),
        .cpu_cyc_start (cpu_cyc_start),
        .cpu_addr_hi   (cpu_addr_hi),
        .cpu_vda       (cpu_vda),
        .clk_is_hs     (clk_is_hs),
        .cfg_wr        (cfg_wr),
        .cfg_wdata     (cfg_wdata),
        .hsclk_sel     (hsclk_sel),
        .hsclk_div_sel (hsclk_div_sel),
        .cpuclk_div_sel(cpuclk_div_sel),
        .cfg_rdata     (cfg_rdata),
        .busy          (busy)
    );

    // Model: the requested clock level plus whether a handshake is outstanding.
    bit         m_sel, m_wait, m_turbo, m_err;
    int         m_wcnt, m_hold;
    logic [1:0] m_hdiv, m_cdiv, m_hdiv_app, m_cdiv_app;

    task automatic model_reset();
        m_sel = 0; m_wait = 0; m_turbo = 0; m_err = 0;
        m_wcnt = 0; m_hold = 0;
        m_hdiv = 2'b00; m_cdiv = 2'b00; m_hdiv_app = 2'b00; m_cdiv_app = 2'b00;
    endtask

    task automatic model_step(input bit st, input logic [7:0] a, input bit v,
                              input bit hs, input bit wr, input logic [7:0] wd);
        bit slow;
        bit timed_out;
        slow = v && (a >= 8'hFC) && (a <= 8'hFE);
        timed_out = 0;
        if (!m_sel && !m_wait && !hs) begin
            m_hdiv_app = m_hdiv;
            m_cdiv_app = m_cdiv;
        end
        if (m_wait) begin
            if (hs == m_sel) begin
                m_wait = 0;
            end else if (m_wcnt == 63) begin
                m_wait = 0; m_sel = 0; timed_out = 1;
            end else if (m_sel && !m_turbo) begin
                m_sel = 0; m_wcnt = 0;
            end else begin
                m_wcnt++;
            end
        end else if (m_sel) begin
            if ((st && slow) || !m_turbo) begin
                m_sel = 0; m_wait = 1; m_wcnt = 0;
            end
        end else if (st && m_turbo && !slow && m_hold == 0) begin
            m_sel = 1; m_wait = 1; m_wcnt = 0;
        end
        if (st) m_hold = slow ? 4 : ((m_hold > 0) ? m_hold - 1 : 0);
        if (timed_out) m_err = 1;
        else if (wr && wd[7]) m_err = 0;
        if (wr) begin
            m_turbo = wd[0];
            m_hdiv  = wd[2:1];
            m_cdiv  = wd[4:3];
        end
    endtask

    function automatic logic [7:0] model_rdata();
        logic [1:0] code;
        code = m_sel ? (m_wait ? 2'd1 : 2'd2) : (m_wait ? 2'd3 : 2'd0);
        return {m_err, code, m_cdiv, m_hdiv, m_turbo};
    endfunction

    task automatic check(input string name, input bit e_sel, input bit e_busy,
                         input logic [1:0] e_hd, input logic [1:0] e_cd, input logic [7:0] e_rd);
        n_vec++;
        if ({hsclk_sel, busy, hsclk_div_sel, cpuclk_div_sel, cfg_rdata} !==
            {e_sel, e_busy, e_hd, e_cd, e_rd}) begin
            n_err++;
            $display("FAIL %s: got sel=%0b busy=%0b hdiv=%0d cdiv=%0d rdata=%02h, expected sel=%0b busy=%0b hdiv=%0d cdiv=%0d rdata=%02h",
                     name, hsclk_sel, busy, hsclk_div_sel, cpuclk_div_sel, cfg_rdata,
                     e_sel, e_busy, e_hd, e_cd, e_rd);
        end
    endtask

    task automatic step(input bit st, input logic [7:0] a, input bit v,
                        input bit hs, input bit wr, input logic [7:0] wd);
        cpu_cyc_start = st; cpu_addr_hi = a; cpu_vda = v;
        clk_is_hs = hs; cfg_wr = wr; cfg_wdata = wd;
        @(posedge clk);
        model_step(st, a, v, hs, wr, wd);
        #1;
    endtask

    task automatic do_reset();
        cpu_cyc_start = 0; cpu_addr_hi = 8'h00; cpu_vda = 0;
        clk_is_hs = 0; cfg_wr = 0; cfg_wdata = 8'h00;
        rst_b = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3 rst_b = 1'b1;
    endtask

    typedef struct {
        bit         st;
        logic [7:0] a;
        bit         v;
        bit         hs;
        bit         wr;
        logic [7:0] wd;
        bit         e_sel;
        bit         e_busy;
        logic [1:0] e_hd;
        logic [1:0] e_cd;
        logic [7:0] e_rd;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit st, input logic [7:0] a, input bit v, input bit hs,
                       input bit wr, input logic [7:0] wd, input bit e_sel, input bit e_busy,
                       input logic [1:0] e_hd, input logic [1:0] e_cd, input logic [7:0] e_rd);
        vec_t r;
        r.st = st; r.a = a; r.v = v; r.hs = hs; r.wr = wr; r.wd = wd;
        r.e_sel = e_sel; r.e_busy = e_busy; r.e_hd = e_hd; r.e_cd = e_cd; r.e_rd = e_rd;
        tbl.push_back(r);
    endtask

    initial begin
        bit stuck;
        bit st, v, hs, wr;
        logic [7:0] a, wd;

        // Directed vectors from reset: turbo off, first switch, I/O hold, deferred dividers.
        add(1'b1, 8'h30, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 2'd0, 8'h00);
        add(1'b1, 8'h30, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 2'd0, 8'h00);
        add(1'b0, 8'h30, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 2'd0, 2'd0, 8'h01);
        add(1'b1, 8'h30, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 2'd0, 8'h21);
        add(1'b0, 8'h30, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 2'd0, 8'h21);
        add(1'b0, 8'h30, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 2'd0, 8'h41);
        add(1'b1, 8'hFD, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 2'd0, 8'h41);
        add(1'b1, 8'hFD, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 2'd0, 8'h61);
        add(1'b0, 8'h30, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 2'd0, 8'h61);
        add(1'b0, 8'h30, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 2'd0, 8'h01);
        for (int i = 0; i < 4; i++)
            add(1'b1, 8'h30, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 2'd0, 8'h01);
        add(1'b1, 8'h30, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 2'd0, 8'h21);
        add(1'b0, 8'h30, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 2'd0, 8'h41);
        add(1'b0, 8'h30, 1'b1, 1'b1, 1'b1, 8'h1F, 1'b1, 1'b0, 2'd0, 2'd0, 8'h5F);
        add(1'b1, 8'hFE, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 2'd0, 8'h7F);
        add(1'b0, 8'h30, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 2'd0, 8'h1F);
        add(1'b0, 8'h30, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 2'd3, 8'h1F);
        add(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 2'd3, 8'h1F);
        for (int i = 0; i < 3; i++)
            add(1'b1, 8'hFB, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 2'd3, 8'h1F);
        add(1'b1, 8'hFC, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 2'd3, 8'h1F);

        do_reset();
        check("reset", 1'b0, 1'b0, 2'd0, 2'd0, 8'h00);
        foreach (tbl[i]) begin
            step(tbl[i].st, tbl[i].a, tbl[i].v, tbl[i].hs, tbl[i].wr, tbl[i].wd);
            check($sformatf("vec%0d", i), tbl[i].e_sel, tbl[i].e_busy, tbl[i].e_hd, tbl[i].e_cd, tbl[i].e_rd);
        end

        // Hold drains after the FC access, then an unacknowledged HS request times out.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'h30, 1'b1, 1'b0, 1'b0, 8'h00);
            check("hold_drain", 1'b0, 1'b0, 2'd3, 2'd3, 8'h1F);
        end
        step(1'b1, 8'h30, 1'b1, 1'b0, 1'b0, 8'h00);
        check("tmo_req", 1'b1, 1'b1, 2'd3, 2'd3, 8'h3F);
        for (int i = 0; i < 63; i++) begin
            step(1'b0, 8'h30, 1'b1, 1'b0, 1'b0, 8'h00);
            check("tmo_wait", 1'b1, 1'b1, 2'd3, 2'd3, 8'h3F);
        end
        step(1'b0, 8'h30, 1'b1, 1'b0, 1'b0, 8'h00);
        check("tmo_fire", 1'b0, 1'b0, 2'd3, 2'd3, 8'h9F);
        step(1'b0, 8'h30, 1'b1, 1'b0, 1'b1, 8'h81);
        check("err_clear", 1'b0, 1'b0, 2'd3, 2'd3, 8'h01);
        step(1'b0, 8'h30, 1'b1, 1'b0, 1'b0, 8'h00);
        check("div_apply", 1'b0, 1'b0, 2'd0, 2'd0, 8'h01);

        // Asynchronous reset in the middle of an HS request.
        step(1'b1, 8'h30, 1'b1, 1'b0, 1'b0, 8'h00);
        check("req_again", 1'b1, 1'b1, 2'd0, 2'd0, 8'h21);
        #2 rst_b = 1'b0;
        #1 check("async_rst", 1'b0, 1'b0, 2'd0, 2'd0, 8'h00);
        model_reset();
        @(posedge clk);
        #3 rst_b = 1'b1;

        // Randomized traffic with a switch that sometimes stalls its acknowledge.
        do_reset();
        stuck = 0;
        hs = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) stuck = ~stuck;
            if (!stuck && $urandom_range(0, 3) == 0) hs = hsclk_sel;
            st = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0: a = 8'hFB;
                1: a = 8'hFC;
                2: a = 8'hFD;
                3: a = 8'hFE;
                4: a = 8'hFF;
                default: a = 8'($urandom);
            endcase
            v  = ($urandom_range(0, 3) != 0);
            wr = ($urandom_range(0, 19) == 0);
            wd = 8'($urandom);
            wd[0] = ($urandom_range(0, 3) != 0);
            step(st, a, v, hs, wr, wd);
            check("random", m_sel, m_wait, m_hdiv_app, m_cdiv_app, model_rdata());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
